addr8u_redundant_sched: RTL and testbench

Time-redundant scheduler that shares one combinational 8-bit unsigned adder (9-bit sum) among NREQ requesters. Each accepted request is computed twice through the shared adder: pass 1 with operands as given, pass 2 with operands swapped. The two results are compared, and on mismatch the pair of passes is retried. The block sits between client logic and an external adder instance, and turns the fault-resilient adder into a checked, arbitrated resource.

---
 rtl/addr8u_redundant_sched.sv | 170 +++++++++++++++++
 tb/tb_addr8u_redundant_sched.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr8u_redundant_sched.sv
// Time-redundant scheduler around a shared external 8-bit adder: each accepted
// request is summed twice (operands swapped on the second pass) and retried on disagreement.
module addr8u_redundant_sched #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned IDW       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_a,
  input  logic [8*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  input  logic [8:0]           add_sum,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [8:0]           rsp_sum,
  output logic                 rsp_err,
  output logic [7:0]           mismatch_cnt,
  output logic                 busy
);

  localparam int unsigned OPW = 8;
  localparam int unsigned SW  = 9;
  localparam int unsigned RW  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_P2,
    S_CMP,
    S_RESP
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic           found;
  logic [OPW-1:0] op_a;
  logic [OPW-1:0] op_b;
  logic [SW-1:0]  s1;
  logic [SW-1:0]  s2;
  logic [RW-1:0]  retry;
  logic           same;
  logic           can_retry;

  // Round-robin pick: first valid requester at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign same      = (s1 == s2);
  assign can_retry = (retry < RW'(MAX_RETRY));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state, accept strobe and adder operand steering.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    case (state)
      S_IDLE: begin
        if (found) begin
          req_ready[win] = 1'b1;
          state_nx       = S_P1;
        end
      end
      S_P1: begin
        add_a    = op_a;
        add_b    = op_b;
        state_nx = S_P2;
      end
      S_P2: begin
        add_a    = op_b;
        add_b    = op_a;
        state_nx = S_CMP;
      end
      S_CMP: begin
        if (same || !can_retry) state_nx = S_RESP;
        else                    state_nx = S_P1;
      end
      S_RESP: begin
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // Reset abandons everything, including an accept that would happen this cycle.
    if (rst) begin
      state_nx  = S_IDLE;
      req_ready = '0;
    end
  end

  // Operand capture, pass results, verdict and arbitration pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      gnt          <= '0;
      op_a         <= '0;
      op_b         <= '0;
      s1           <= '0;
      s2           <= '0;
      retry        <= '0;
      rsp_id       <= '0;
      rsp_sum      <= '0;
      rsp_err      <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            gnt   <= win;
            op_a  <= req_a[OPW*int'(win) +: OPW];
            op_b  <= req_b[OPW*int'(win) +: OPW];
            retry <= '0;
          end
        end
        S_P1: s1 <= add_sum;
        S_P2: s2 <= add_sum;
        S_CMP: begin
          if (same) begin
            rsp_id  <= gnt;
            rsp_sum <= s1;
            rsp_err <= 1'b0;
          end else begin
            if (mismatch_cnt != 8'hFF) mismatch_cnt <= mismatch_cnt + 8'd1;
            if (can_retry) begin
              retry <= retry + RW'(1);
            end else begin
              rsp_id  <= gnt;
              rsp_sum <= s1;
              rsp_err <= 1'b1;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            if (int'(gnt) == int'(NREQ) - 1) ptr <= '0;
            else                             ptr <= gnt + IDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_addr8u_redundant_sched.sv
// Self-checking bench for addr8u_redundant_sched: directed scenarios plus
// randomized traffic against a transaction-level model with an injectable adder fault.
module tb_addr8u_redundant_sched;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned MAX_RETRY = 2;
  localparam int unsigned IDW       = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [8*NREQ-1:0]   req_a;
  logic [8*NREQ-1:0]   req_b;
  logic [NREQ-1:0]     req_ready;
  logic [7:0]          add_a;
  logic [7:0]          add_b;
  logic [8:0]          add_sum;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [8:0]          rsp_sum;
  logic                rsp_err;
  logic [7:0]          mismatch_cnt;
  logic                busy;

  int n_cmp = 0;
  int n_bad = 0;
  int fault_mode = 0;
  int cyc_since = 0;

  addr8u_redundant_sched #(.NREQ(NREQ), .MAX_RETRY(MAX_RETRY), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_err(rsp_err), .mismatch_cnt(mismatch_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycles since the last accept edge: 1 = first pass, 2 = first swapped pass, +3 per retry.
  always @(posedge clk) begin
    if (rst)                 cyc_since <= 0;
    else if (req_ready != 0) cyc_since <= 1;
    else                     cyc_since <= cyc_since + 1;
  end

  // External adder: ideal, optionally corrupting bit 3 on swapped passes.
  always_comb begin
    add_sum = 9'(add_a) + 9'(add_b);
    if ((fault_mode == 1 && cyc_since == 2) || (fault_mode == 2 && (cyc_since % 3) == 2))
      add_sum = add_sum ^ 9'h008;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    fault_mode = 0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Model of one request's outcome under the adder fault mode.
  function automatic int model_mm(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'(MAX_RETRY) + 1;
  endfunction

  function automatic int model_lat(input int mode);
    int r;
    r = model_mm(mode);
    if (r > int'(MAX_RETRY)) r = int'(MAX_RETRY);
    return 4 + 3 * r;
  endfunction

  // Issues one request and reports what came back (no judging here).
  task automatic do_req(input int idx, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [IDW-1:0] id, output logic [8:0] sum,
                        output logic err, output int grants);
    int acc;
    bit got;
    lat = -1; id = '0; sum = '0; err = 1'b0; grants = 0; acc = 0; got = 0;
    req_a[8*idx +: 8] = a;
    req_b[8*idx +: 8] = b;
    req_valid[idx] = 1'b1;
    rsp_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        grants++;
        if (!got) begin got = 1; acc = t; end
      end
      if (rsp_valid) begin
        lat = t - acc; id = rsp_id; sum = rsp_sum; err = rsp_err;
      end
      next_cycle();
      if (got) req_valid[idx] = 1'b0;
      if (lat >= 0) break;
    end
    req_valid[idx] = 1'b0;
  endtask

  task automatic test_reset();
    logic [48:0] outs;
    rst = 1'b1;
    req_valid = '1;
    req_a = 32'h11223344;
    req_b = 32'h55667788;
    rsp_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    outs = {req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_err, mismatch_cnt, busy};
    n_cmp++;
    if (outs !== 49'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    end
    next_cycle();
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    int lat, gr;
    logic [IDW-1:0] id;
    logic [8:0] sum;
    logic err;
    do_reset();
    do_req(0, 8'd200, 8'd100, lat, id, sum, err, gr);
    n_cmp++; if (gr !== 1) begin n_bad++; $display("FAIL single_grants: got %0d want 1", gr); end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL single_latency: got %0d want 4", lat); end
    n_cmp++; if (id !== 2'd0) begin n_bad++; $display("FAIL single_id: got %0d want 0", id); end
    n_cmp++; if (sum !== 9'h12C) begin n_bad++; $display("FAIL single_sum: got %h want 12c", sum); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", err); end
    n_cmp++; if (mismatch_cnt !== 8'd0) begin n_bad++; $display("FAIL single_mm: got %0d want 0", mismatch_cnt); end
  endtask

  task automatic test_round_robin();
    int ids[$];
    int want[5] = '{0, 1, 2, 3, 0};
    logic [7:0] a, b;
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) begin
      req_a[8*i +: 8] = 8'(i * 37 + 5);
      req_b[8*i +: 8] = 8'(i * 11 + 200);
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int t = 0; t < 40 && ids.size() < 5; t++) begin
      @(negedge clk);
      n_cmp++;
      if ($countones(req_ready) > 1) begin
        n_bad++; $display("FAIL rr_onehot: got %b want at most one bit", req_ready);
      end
      if (rsp_valid) begin
        ids.push_back(int'(rsp_id));
        a = 8'(int'(rsp_id) * 37 + 5);
        b = 8'(int'(rsp_id) * 11 + 200);
        n_cmp++;
        if (rsp_sum !== 9'(a) + 9'(b)) begin
          n_bad++; $display("FAIL rr_sum: got %h want %h", rsp_sum, 9'(a) + 9'(b));
        end
      end
      next_cycle();
    end
    req_valid = '0;
    n_cmp++;
    if (ids.size() != 5) begin
      n_bad++; $display("FAIL rr_count: got %0d want 5", ids.size());
    end
    for (int i = 0; i < 5 && i < ids.size(); i++) begin
      n_cmp++;
      if (ids[i] != want[i]) begin
        n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, ids[i], want[i]);
      end
    end
  endtask

  task automatic test_retry_once();
    int lat, gr;
    logic [IDW-1:0] id;
    logic [8:0] sum;
    logic err;
    do_reset();
    fault_mode = 1;
    do_req(0, 8'd15, 8'd1, lat, id, sum, err, gr);
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL retry1_latency: got %0d want 7", lat); end
    n_cmp++; if (sum !== 9'd16) begin n_bad++; $display("FAIL retry1_sum: got %0d want 16", sum); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL retry1_err: got %b want 0", err); end
    n_cmp++; if (mismatch_cnt !== 8'd1) begin n_bad++; $display("FAIL retry1_mm: got %0d want 1", mismatch_cnt); end
    fault_mode = 0;
  endtask

  task automatic test_persistent();
    int lat, gr;
    logic [IDW-1:0] id;
    logic [8:0] sum;
    logic err;
    do_reset();
    fault_mode = 2;
    do_req(0, 8'd255, 8'd255, lat, id, sum, err, gr);
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL persist_latency: got %0d want 10", lat); end
    n_cmp++; if (sum !== 9'h1FE) begin n_bad++; $display("FAIL persist_sum: got %h want 1fe", sum); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL persist_err: got %b want 1", err); end
    n_cmp++; if (mismatch_cnt !== 8'd3) begin n_bad++; $display("FAIL persist_mm: got %0d want 3", mismatch_cnt); end
    fault_mode = 0;
  endtask

  task automatic test_backpressure();
    bit seen;
    seen = 0;
    do_reset();
    req_a[8*2 +: 8] = 8'd77;
    req_b[8*2 +: 8] = 8'd99;
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = rsp_valid;
      next_cycle();
      if (req_ready == 0 && busy) req_valid = 4'b0000;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL bp_rsp_seen: got 0 want 1"); end
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_err} !== {1'b1, 2'd2, 9'd176, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%0d err=%b want v=1 id=2 sum=176 err=0",
                 k, rsp_valid, rsp_id, rsp_sum, rsp_err);
      end
      n_cmp++;
      if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready); end
      next_cycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hs_valid: got %b want 1", rsp_valid); end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL bp_after: got v=%b busy=%b want 0 0", rsp_valid, busy); end
    n_cmp++;
    if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL bp_next_grant: got %b want 1000", req_ready); end
    next_cycle();
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    int lat, gr;
    logic [IDW-1:0] id;
    logic [8:0] sum;
    logic err;
    logic [48:0] outs;
    bit seen;
    do_reset();
    do_req(2, 8'd10, 8'd20, lat, id, sum, err, gr);
    req_a[7:0] = 8'd1;
    req_b[7:0] = 8'd2;
    req_valid = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rstmid_grant0: got %b want 0001", req_ready); end
    next_cycle();
    req_a[15:8] = 8'd50; req_b[15:8] = 8'd60;
    req_a[31:24] = 8'd70; req_b[31:24] = 8'd80;
    req_valid = 4'b1010;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, req_ready} !== 5'b10000) begin
      n_bad++; $display("FAIL rstmid_p2: got busy=%b ready=%b want busy=1 ready=0000", busy, req_ready);
    end
    next_cycle();
    @(negedge clk);
    outs = {req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_err, mismatch_cnt, busy};
    n_cmp++;
    if (outs !== 49'd0) begin n_bad++; $display("FAIL rstmid_outputs: got %h want 0", outs); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL rstmid_rearb: got %b want 0010", req_ready); end
    next_cycle();
    req_valid = 4'b0000;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        n_cmp++;
        if ({rsp_id, rsp_sum} !== {2'd1, 9'd110}) begin
          n_bad++; $display("FAIL rstmid_rsp: got id=%0d sum=%0d want id=1 sum=110", rsp_id, rsp_sum);
        end
      end
      next_cycle();
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL rstmid_rsp_seen: got 0 want 1"); end
  endtask

  task automatic test_saturation();
    int lat, gr;
    logic [IDW-1:0] id;
    logic [8:0] sum;
    logic err;
    do_reset();
    fault_mode = 2;
    for (int r = 1; r <= 100; r++) begin
      do_req(0, 8'd1, 8'd2, lat, id, sum, err, gr);
      if (r == 84) begin
        n_cmp++;
        if (mismatch_cnt !== 8'd252) begin n_bad++; $display("FAIL sat_84: got %0d want 252", mismatch_cnt); end
      end
      if (r == 85) begin
        n_cmp++;
        if (mismatch_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_85: got %0d want 255", mismatch_cnt); end
      end
    end
    n_cmp++;
    if (mismatch_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_300: got %0d want 255", mismatch_cnt); end
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL sat_err: got %b want 1", err); end
    fault_mode = 0;
  endtask

  task automatic test_random(input int mode, input int ncyc);
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] exp_rdy;
    logic [7:0] pa[NREQ];
    logic [7:0] pb[NREQ];
    logic [8:0] cur_sum;
    int ptr_m, cur, acc_at, nresp, mm_tot, win, lat_m, mm_m, mm_exp, j;
    bit outst, err_m, exp_v;
    do_reset();
    fault_mode = mode;
    mm_m = model_mm(mode);
    lat_m = model_lat(mode);
    err_m = (mm_m > int'(MAX_RETRY));
    pend = '0; ptr_m = 0; outst = 0; mm_tot = 0; nresp = 0; cur = 0; acc_at = 0; cur_sum = '0;
    for (int t = 0; t < ncyc; t++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1'b1;
          pa[i] = 8'($urandom);
          pb[i] = 8'($urandom);
          req_a[8*i +: 8] = pa[i];
          req_b[8*i +: 8] = pb[i];
        end
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(2) != 0);
      @(negedge clk);
      exp_rdy = '0;
      win = -1;
      if (!outst) begin
        for (int k = 0; k < int'(NREQ); k++) begin
          j = (ptr_m + k) % int'(NREQ);
          if (win < 0 && pend[j]) win = j;
        end
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
      n_cmp++;
      if (req_ready !== exp_rdy) begin
        n_bad++; $display("FAIL rand%0d_ready t=%0d: got %b want %b", mode, t, req_ready, exp_rdy);
      end
      exp_v = outst && (t >= acc_at + lat_m);
      n_cmp++;
      if (rsp_valid !== exp_v) begin
        n_bad++; $display("FAIL rand%0d_valid t=%0d: got %b want %b", mode, t, rsp_valid, exp_v);
      end
      if (exp_v && rsp_ready) begin
        mm_tot += mm_m;
        mm_exp = (mm_tot > 255) ? 255 : mm_tot;
        n_cmp++;
        if ({rsp_id, rsp_sum, rsp_err} !== {2'(cur), cur_sum, err_m}) begin
          n_bad++;
          $display("FAIL rand%0d_rsp t=%0d: got id=%0d sum=%h err=%b want id=%0d sum=%h err=%b",
                   mode, t, rsp_id, rsp_sum, rsp_err, cur, cur_sum, err_m);
        end
        n_cmp++;
        if (int'(mismatch_cnt) != mm_exp) begin
          n_bad++; $display("FAIL rand%0d_mm t=%0d: got %0d want %0d", mode, t, mismatch_cnt, mm_exp);
        end
        ptr_m = (cur + 1) % int'(NREQ);
        outst = 0;
        nresp++;
      end
      if (win >= 0) begin
        outst = 1; cur = win; acc_at = t;
        cur_sum = 9'(pa[win]) + 9'(pb[win]);
        pend[win] = 1'b0;
      end
      next_cycle();
    end
    req_valid = '0;
    n_cmp++;
    if (nresp < 5) begin n_bad++; $display("FAIL rand%0d_progress: got %0d responses want >= 5", mode, nresp); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_retry_once();
    test_persistent();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_random(0, 300);
    test_random(1, 300);
    test_random(2, 300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
